// File: rtl/bs_serial_loader_pkg.sv
// bs_pkg: shared widths and FSM state type for the nibble-serial barrel
// shifter front end (bs_serial_loader and BS_16bit).
package bs_pkg;

    localparam int unsigned WIDTH    = 16;
    localparam int unsigned NIBBLES  = 4;
    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SAMT,
        ROT,
        DONE
    } bs_state_t;

endpackage

// File: rtl/bs_serial_loader_if.sv
// bs_serial_loader_if: handshake/data bundle between the input path and
// bs_serial_loader.
//   start  : begin a transaction (master -> slave)
//   din    : operand nibbles then rotate amount (master -> slave)
//   busy   : transaction in progress (slave -> master)
//   done   : one-cycle strobe, result newly valid (slave -> master)
//   result : registered rotated word (slave -> master)
interface bs_serial_loader_if;
    import bs_pkg::*;

    logic                start;
    logic [NIBBLE_W-1:0] din;
    logic                busy;
    logic                done;
    logic [WIDTH-1:0]    result;

    modport master (
        output start, din,
        input  busy, done, result
    );

    modport slave (
        input  start, din,
        output busy, done, result
    );

endinterface

// File: rtl/bs_serial_loader_bs16.sv
// BS_16bit: combinational 16-bit rotate-right.
//   A : operand word
//   s : rotate amount (0..15)
//   w : A rotated right by s, w[i] = A[(i + s) mod 16]
module BS_16bit
    import bs_pkg::*;
(
    input  logic [WIDTH-1:0]    A,
    input  logic [NIBBLE_W-1:0] s,
    output logic [WIDTH-1:0]    w
);

    // For s = 0 the left shift amount is 16, which yields zero, so A passes through.
    logic [4:0] w_lsh;

    assign w_lsh = 5'd16 - {1'b0, s};
    assign w     = (A >> s) | (A << w_lsh);

endmodule

// File: rtl/bs_serial_loader.sv
// bs_serial_loader: collects a 16-bit operand (LSB nibble first) and a 4-bit
// rotate amount over a nibble bus after a start pulse, rotates right through
// one BS_16bit, registers the result and strobes done for one cycle.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of bs_serial_loader_if (start, din, busy, done, result)
module bs_serial_loader
    import bs_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    bs_serial_loader_if.slave   bus
);

    bs_state_t           r_state;
    bs_state_t           w_next;
    logic [1:0]          r_cnt;
    logic [WIDTH-1:0]    r_a;
    logic [NIBBLE_W-1:0] r_s;
    logic [WIDTH-1:0]    r_result;
    logic                r_busy;
    logic                r_done;
    logic [WIDTH-1:0]    w_rot;

    BS_16bit u_bs (
        .A (r_a),
        .s (r_s),
        .w (w_rot)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = LOAD;
            LOAD:    if (r_cnt == 2'd3) w_next = SAMT;
            SAMT:    w_next = ROT;
            ROT:     w_next = DONE;
            DONE:    w_next = bus.start ? LOAD : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // busy/done are registered from the next state, so they track the state
    // register exactly while having no path from inputs to outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_s      <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == LOAD) || (w_next == SAMT) || (w_next == ROT);
            r_done  <= (w_next == DONE);
            case (r_state)
                IDLE: if (bus.start) r_cnt <= '0;
                LOAD: begin
                    r_a[{r_cnt, 2'b00} +: NIBBLE_W] <= bus.din;
                    r_cnt <= r_cnt + 2'd1;
                end
                SAMT: r_s <= bus.din;
                ROT:  r_result <= w_rot;
                DONE: if (bus.start) r_cnt <= '0;
                default: ;
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;

endmodule
